// File: rtl/lab3_cache_mem_arbiter.sv
// Two-requester (icache/dcache) round-robin arbiter onto one memory port, with an
// in-order ID FIFO that steers memory responses back to the requester that issued them.
module lab3_cache_mem_arbiter #(
  parameter int REQ_W  = 77,
  parameter int RESP_W = 47,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_val,
  output logic                      req0_rdy,
  input  logic [REQ_W-1:0]          req0_msg,
  output logic                      resp0_val,
  input  logic                      resp0_rdy,
  output logic [RESP_W-1:0]         resp0_msg,
  input  logic                      req1_val,
  output logic                      req1_rdy,
  input  logic [REQ_W-1:0]          req1_msg,
  output logic                      resp1_val,
  input  logic                      resp1_rdy,
  output logic [RESP_W-1:0]         resp1_msg,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [REQ_W-1:0]          mem_req_msg,
  input  logic                      mem_resp_val,
  output logic                      mem_resp_rdy,
  input  logic [RESP_W-1:0]         mem_resp_msg,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err
);

  // Handshake: a message moves on a port only in a cycle where its val and rdy are
  // both high; a producer holds val and msg stable until that cycle.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       lock_state;
  logic             lock_id;
  logic             prio;
  logic             winner;
  logic             full;
  logic             empty;
  logic             head;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] id_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_q;

  // A stalled offer keeps its requester until it transfers, regardless of prio.
  always_comb begin
    winner = 1'b0;
    if (lock_state == ST_LOCKED) begin
      winner = lock_id;
    end else if (req0_val && req1_val) begin
      winner = prio;
    end else begin
      winner = req1_val;
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  // Request side depends only on registered count, never on the response port.
  assign mem_req_val = (req0_val | req1_val) & ~full & reset;
  assign mem_req_msg = winner ? req1_msg : req0_msg;
  assign req0_rdy    = ~winner & mem_req_rdy & ~full & reset;
  assign req1_rdy    =  winner & mem_req_rdy & ~full & reset;

  assign resp0_msg    = mem_resp_msg;
  assign resp1_msg    = mem_resp_msg;
  assign resp0_val    = mem_resp_val & ~empty & ~head;
  assign resp1_val    = mem_resp_val & ~empty &  head;
  assign mem_resp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);

  assign push = mem_req_val & mem_req_rdy;
  assign pop  = mem_resp_val & mem_resp_rdy;

  assign outstanding = count;
  assign err         = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_state <= ST_OPEN;
      lock_id    <= 1'b0;
      prio       <= 1'b0;
    end else if (push) begin
      lock_state <= ST_OPEN;
      prio       <= ~winner;
    end else if (mem_req_val) begin
      lock_state <= ST_LOCKED;
      lock_id    <= winner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= winner;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A response with nothing outstanding is a protocol error; it is never accepted.
      if (mem_resp_val && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Bench for lab3_cache_mem_arbiter: directed scenarios plus randomized traffic, all
// outputs compared each cycle against a queue-based reference model.
module tb_lab3_cache_mem_arbiter;

  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              req0_val, req0_rdy, req1_val, req1_rdy;
  logic [REQ_W-1:0]  req0_msg, req1_msg, mem_req_msg;
  logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RESP_W-1:0] resp0_msg, resp1_msg, mem_resp_msg;
  logic              mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [CNT_W-1:0]  outstanding;
  logic              err;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_q[$];
  logic m_prio, m_lock, m_lock_id, m_err;
  // model predictions for the current cycle
  logic e_win, e_full, e_empty, e_mrv, e_r0r, e_r1r, e_head, e_p0v, e_p1v, e_mrr;
  logic acc0, acc1, accm;

  // response scoreboard
  logic [RESP_W-1:0] exp0_q[$];
  logic [RESP_W-1:0] exp1_q[$];
  logic              sb_on;
  logic [RESP_W-1:0] ord_d[3];
  logic [RESP_W-1:0] sb_exp;

  lab3_cache_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .outstanding(outstanding), .err(err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  function automatic logic [REQ_W-1:0] rand_req();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[REQ_W-1:0];
  endfunction

  function automatic logic [RESP_W-1:0] rand_resp();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RESP_W-1:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prio    = 1'b0;
    m_lock    = 1'b0;
    m_lock_id = 1'b0;
    m_err     = 1'b0;
  endtask

  // Round-robin with a stalled offer held; IDs kept as an ordered list of requesters.
  task automatic compute_exp();
    e_full  = (m_q.size() == DEPTH);
    e_empty = (m_q.size() == 0);
    if (m_lock)                     e_win = m_lock_id;
    else if (req0_val && req1_val)  e_win = m_prio;
    else                            e_win = req1_val;
    e_mrv  = (req0_val || req1_val) && !e_full;
    e_r0r  = !e_win && mem_req_rdy && !e_full;
    e_r1r  =  e_win && mem_req_rdy && !e_full;
    e_head = e_empty ? 1'b0 : m_q[0];
    e_p0v  = mem_resp_val && !e_empty && !e_head;
    e_p1v  = mem_resp_val && !e_empty &&  e_head;
    e_mrr  = !e_empty && (e_head ? resp1_rdy : resp0_rdy);
  endtask

  // Observe at the falling edge and compare every output with the model.
  task automatic settle();
    @(negedge clk);
    compute_exp();
    chk_b("mem_req_val", mem_req_val, e_mrv);
    chk_b("req0_rdy", req0_rdy, e_r0r);
    chk_b("req1_rdy", req1_rdy, e_r1r);
    if (e_mrv) chk("mem_req_msg", 128'(mem_req_msg), 128'(e_win ? req1_msg : req0_msg));
    chk_b("resp0_val", resp0_val, e_p0v);
    chk_b("resp1_val", resp1_val, e_p1v);
    chk_b("mem_resp_rdy", mem_resp_rdy, e_mrr);
    chk("resp0_msg", 128'(resp0_msg), 128'(mem_resp_msg));
    chk("resp1_msg", 128'(resp1_msg), 128'(mem_resp_msg));
    chk("outstanding", 128'(outstanding), 128'(m_q.size()));
    chk_b("err", err, m_err);
    acc0 = req0_val && e_r0r;
    acc1 = req1_val && e_r1r;
    accm = mem_resp_val && e_mrr;
    if (sb_on && resp0_val && resp0_rdy) begin
      sb_exp = (exp0_q.size() > 0) ? exp0_q.pop_front() : 'x;
      chk("sb_resp0_data", 128'(resp0_msg), 128'(sb_exp));
    end
    if (sb_on && resp1_val && resp1_rdy) begin
      sb_exp = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
      chk("sb_resp1_data", 128'(resp1_msg), 128'(sb_exp));
    end
  endtask

  // Advance the model with this cycle's transfers, then cross the rising edge.
  task automatic tick();
    if (mem_resp_val && e_empty) m_err = 1'b1;
    if (mem_resp_val && e_mrr) void'(m_q.pop_front());
    if (e_mrv && mem_req_rdy) begin
      m_q.push_back(e_win);
      m_prio = !e_win;
      m_lock = 1'b0;
    end else if (e_mrv) begin
      m_lock    = 1'b1;
      m_lock_id = e_win;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_val = 1'b0; req1_val = 1'b0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
  endtask

  initial begin
    // reset state: outputs quiet even with traffic presented
    reset = 1'b0;
    sb_on = 1'b0;
    idle_inputs();
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1;
    req0_msg = rand_req(); req1_msg = rand_req(); mem_resp_msg = rand_resp();
    model_reset();
    #3;
    chk_b("rst_mem_req_val", mem_req_val, 1'b0);
    chk_b("rst_req0_rdy", req0_rdy, 1'b0);
    chk_b("rst_req1_rdy", req1_rdy, 1'b0);
    chk_b("rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk_b("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;

    // alternation: grants 0,1,0,1 then full
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_b("alt_grant0", req0_rdy, (i % 2) == 0);
      chk_b("alt_grant1", req1_rdy, (i % 2) == 1);
      tick();
      req0_msg = rand_req(); req1_msg = rand_req();
    end
    settle();
    chk("alt_outstanding", 128'(outstanding), 128'(4));
    chk_b("alt_full_rdy0", req0_rdy, 1'b0);
    chk_b("alt_full_rdy1", req1_rdy, 1'b0);
    tick();
    req0_val = 1'b0; req1_val = 1'b0;
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_b("alt_fifo_id", resp1_val, (i % 2) == 1);
      tick();
    end
    idle_inputs();

    // lock hold: req1 stalled, req0 arrives while stalled
    req1_val = 1'b1; req1_msg = rand_req();
    settle(); chk("lock_msg_c1", 128'(mem_req_msg), 128'(req1_msg)); tick();
    req0_val = 1'b1; req0_msg = rand_req();
    settle(); chk("lock_msg_c2", 128'(mem_req_msg), 128'(req1_msg));
    chk_b("lock_r0_c2", req0_rdy, 1'b0); tick();
    settle(); chk("lock_msg_c3", 128'(mem_req_msg), 128'(req1_msg)); tick();
    mem_req_rdy = 1'b1;
    settle(); chk_b("lock_xfer", req1_rdy, 1'b1); tick();
    req1_val = 1'b0;
    settle(); chk_b("lock_next_r0", req0_rdy, 1'b1); tick();
    idle_inputs();

    // back-pressure: head ID is 1, resp1 not ready for 2 cycles
    mem_resp_val = 1'b1; mem_resp_msg = rand_resp(); resp0_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_b("bp_resp1_val", resp1_val, 1'b1);
      chk_b("bp_no_rdy", mem_resp_rdy, 1'b0);
      tick();
      chk("bp_no_pop", 128'(outstanding), 128'(2));
    end
    resp1_rdy = 1'b1;
    settle(); chk_b("bp_pop_rdy", mem_resp_rdy, 1'b1); tick();
    chk("bp_popped", 128'(outstanding), 128'(1));
    mem_resp_msg = rand_resp();
    settle(); tick();
    idle_inputs();

    // ordered responses: IDs 0,1,0 answered with A,B,C
    mem_req_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_val = (i != 1); req1_val = (i == 1);
      req0_msg = rand_req(); req1_msg = rand_req();
      settle(); tick();
    end
    idle_inputs();
    ord_d[0] = RESP_W'(47'hA); ord_d[1] = RESP_W'(47'hB); ord_d[2] = RESP_W'(47'hC);
    exp0_q.push_back(ord_d[0]); exp1_q.push_back(ord_d[1]); exp0_q.push_back(ord_d[2]);
    sb_on = 1'b1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1; mem_resp_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_msg = ord_d[i];
      settle(); tick();
    end
    mem_resp_val = 1'b0;
    settle();
    chk("ord_sb0_left", 128'(exp0_q.size()), 128'(0));
    chk("ord_sb1_left", 128'(exp1_q.size()), 128'(0));
    sb_on = 1'b0;
    tick();
    idle_inputs();

    // full plus pop: no push in the popping cycle, push next cycle
    req0_val = 1'b1; mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_msg = rand_req();
      settle(); tick();
    end
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; mem_resp_msg = rand_resp();
    settle();
    chk_b("fp_r0_blocked", req0_rdy, 1'b0);
    chk_b("fp_pop_rdy", mem_resp_rdy, 1'b1);
    tick();
    mem_resp_val = 1'b0;
    settle();
    chk("fp_outstanding3", 128'(outstanding), 128'(3));
    chk_b("fp_push_next", req0_rdy, 1'b1);
    tick();
    chk("fp_outstanding4", 128'(outstanding), 128'(4));
    req0_val = 1'b0; mem_resp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    idle_inputs();

    // randomized traffic; requesters and memory hold val until accepted
    acc0 = 1'b0; acc1 = 1'b0; accm = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!req0_val || acc0) begin
        req0_val = ($urandom_range(0, 99) < 60); req0_msg = rand_req();
      end
      if (!req1_val || acc1) begin
        req1_val = ($urandom_range(0, 99) < 60); req1_msg = rand_req();
      end
      if (!mem_resp_val || accm) begin
        mem_resp_val = (m_q.size() > 0) && ($urandom_range(0, 99) < 50);
        mem_resp_msg = rand_resp();
      end
      mem_req_rdy = ($urandom_range(0, 99) < 70);
      resp0_rdy   = ($urandom_range(0, 99) < 70);
      resp1_rdy   = ($urandom_range(0, 99) < 70);
      settle(); tick();
    end
    idle_inputs();
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 20 && m_q.size() > 0; i++) begin
      mem_resp_val = 1'b1; mem_resp_msg = rand_resp();
      settle(); tick();
    end
    idle_inputs();
    settle();
    chk("rand_drained", 128'(outstanding), 128'(0));
    tick();

    // error: response when nothing outstanding
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    settle();
    chk_b("err_no_rdy", mem_resp_rdy, 1'b0);
    chk_b("err_no_resp0", resp0_val, 1'b0);
    chk_b("err_no_resp1", resp1_val, 1'b0);
    tick();
    idle_inputs();
    settle(); chk_b("err_set", err, 1'b1); tick();
    settle(); chk_b("err_sticky", err, 1'b1); tick();

    // reset mid-traffic with two outstanding and prio pointing at requester 1
    req0_val = 1'b1; mem_req_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0_msg = rand_req(); settle(); tick();
    end
    req1_val = 1'b1; req1_msg = rand_req();
    settle();
    chk("mid_outstanding", 128'(outstanding), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_outstanding", 128'(outstanding), 128'(0));
    chk_b("ar_err", err, 1'b0);
    chk_b("ar_mem_req_val", mem_req_val, 1'b0);
    chk_b("ar_req0_rdy", req0_rdy, 1'b0);
    chk_b("ar_req1_rdy", req1_rdy, 1'b0);
    model_reset();
    @(posedge clk); #1;
    chk_b("ar_hold_val", mem_req_val, 1'b0);
    chk("ar_hold_out", 128'(outstanding), 128'(0));
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;

    // stale response after reset is an error; prio back at requester 0
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    settle(); chk_b("stale_no_rdy", mem_resp_rdy, 1'b0); tick();
    idle_inputs();
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1;
    req0_msg = rand_req(); req1_msg = rand_req();
    settle();
    chk_b("stale_err", err, 1'b1);
    chk_b("rst_prio_r0", req0_rdy, 1'b1);
    chk_b("rst_prio_r1", req1_rdy, 1'b0);
    tick();
    idle_inputs();
    settle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
